plic_core: RTL and testbench
============================

// Module: plic_core
// PURPOSE
//  Platform-level interrupt controller core behind the slave-3 AXI register port. Three peripheral
//  interrupts (AES, DMA, SD host) pass through level gateways into pending bits. Enabled pending
//  sources are arbitrated by priority and compared against a threshold to drive irq_out to the CPU.
//  The CPU claims the winning source ID by a register read and retires it by a complete write.
// PARAMETERS
//  ADDR_WIDTH  32  width of addr; only addr[11:0] is decoded
//  DATA_WIDTH  32  width of wr_data / rd_data
//  PRIO_BITS   3   priority / threshold width (0 = never interrupts)
// PORTS
//  clk_i              in   1           system clock
//  rst_i              in   1           asynchronous reset, active high
//  aes_interrupt      in   1           source ID 1, level, clk_i domain
//  dma_interrupt      in   1           source ID 2, level, clk_i domain
//  sd_host_interrupt  in   1           source ID 3, level, clk_i domain
//  addr               in   ADDR_WIDTH  register byte address (word aligned)
//  wr_en              in   1           1-cycle write strobe
//  rd_en              in   1           1-cycle read strobe
//  wr_data            in   DATA_WIDTH  write data
//  rd_data            out  DATA_WIDTH  read data, registered
//  irq_out            out  1           interrupt request to CPU, registered
// BEHAVIOUR
//  Reset values:
//  - All registers 0, pending 0, in_flight 0, rd_data 0, irq_out 0.
//  Register map (addr[11:0]):
//  - 0x004/0x008/0x00C: PRIO[1..3], RW, low PRIO_BITS bits. 0x000 reads 0, writes ignored.
//  - 0x080: PENDING, RO, bits[3:1]; bit0 always 0.
//  - 0x100: ENABLE, RW, bits[3:1]; bit0 reads 0.
//  - 0x104: THRESHOLD, RW, low PRIO_BITS bits.
//  - 0x108: CLAIM on read / COMPLETE on write.
//  - Unmapped reads return 0; unmapped writes are ignored; writes to RO bits are ignored.
//  Writes:
//  - Take effect at the clk_i edge where wr_en=1. Unwritten fields are zero-extended.
//  Reads:
//  - rd_data is updated at the edge where rd_en=1 and holds until the next read.
//  - Latency is 1 cycle: data is valid the cycle after the rd_en cycle.
//  - If wr_en and rd_en are both 1 in the same cycle, the write wins and the read is ignored.
//  Gateway, per source i:
//  - pending[i] sets at the next edge when src_i=1 && !pending[i] && !in_flight[i].
//  - While in_flight[i]=1, src_i is masked.
//  - If src_i is still high after COMPLETE, pending re-sets one cycle after in_flight clears.
//  Arbitration (combinational):
//  - Candidates are sources with pending & enable & prio!=0.
//  - best = candidate with the highest prio; ties go to the lowest ID; best_id=0 if none.
//  - irq_out is registered: next irq_out = (best_id!=0) && (prio[best_id] > threshold).
//  CLAIM read:
//  - rd_data <= best_id, evaluated regardless of threshold.
//  - If best_id!=0, pending[best_id] clears and in_flight[best_id] sets at the same edge.
//  - A gateway set of the claimed source in that cycle is suppressed (claim wins).
//  - Claim with no candidate returns 0 and changes no state.
//  COMPLETE write:
//  - ID = wr_data[1:0]. Clears in_flight[ID] only if in_flight[ID]=1.
//  - ID 0 or a non-in-flight ID is ignored silently.
//  Register changes:
//  - Changing ENABLE/PRIO/THRESHOLD re-evaluates irq_out the next cycle; pending is not cleared.
//  Reset mid-operation:
//  - rst_i asserted at any time immediately returns all state to reset values.
//  - After release, a source still high pends 1 cycle later.
// TESTING
//  1. PRIO1=3, ENABLE=0x2, THR=0, pulse aes high -> PENDING=0x2 at +1, irq_out=1 at +2;
//     CLAIM returns 1, irq_out=0 two cycles later.
//  2. PRIO1=2, PRIO2=5, PRIO3=5, ENABLE=0xE, all sources high -> CLAIM returns 2,
//     next CLAIM returns 3, next returns 1, then 0.
//  3. PRIO3=2, THR=2, sd_host high -> irq_out stays 0; THR=1 -> irq_out=1;
//     CLAIM with THR=2 still returns 3.
//  4. Claim ID 2, keep dma high -> PENDING bit2 stays 0; COMPLETE wr_data=2 ->
//     PENDING=0x4 the cycle after next; COMPLETE 1 (not in flight) -> no state change.
//  5. Claim on the same edge the claimed source's gateway would set -> no re-pend;
//     wr_en+rd_en together -> write applied, rd_data unchanged.
//  6. Assert rst_i mid-claim with irq_out=1 -> irq_out, rd_data, PENDING, ENABLE all 0 immediately.

Source files
------------

// File: rtl/plic_core.sv
// Three-source platform-level interrupt controller core: level gateways, priority
// arbitration against a threshold, and a claim/complete register interface.
module plic_core #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int PRIO_BITS  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  aes_interrupt,
   input  logic                  dma_interrupt,
   input  logic                  sd_host_interrupt,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  irq_out
);

   logic [3:1][PRIO_BITS-1:0] prio;
   logic [3:1]                enable;
   logic [PRIO_BITS-1:0]      threshold;
   logic [3:1]                pending;
   logic [3:1]                in_flight;

   logic [3:1]                src;
   logic [3:1]                candidates;
   logic [1:0]                best_id;
   logic [PRIO_BITS-1:0]      best_prio;
   logic [11:0]               reg_addr;
   logic                      do_write;
   logic                      do_read;
   logic                      claim;
   logic [3:1]                claim_mask;
   logic [3:1]                complete_mask;
   logic [3:1]                pending_next;
   logic [3:1]                in_flight_next;
   logic [DATA_WIDTH-1:0]     rd_mux;
   logic                      unused_bits;

   assign src         = {sd_host_interrupt, dma_interrupt, aes_interrupt};
   assign reg_addr    = addr[11:0];
   assign do_write    = wr_en;
   assign do_read     = rd_en & ~wr_en;
   assign unused_bits = ^{addr[ADDR_WIDTH-1:12], wr_data[DATA_WIDTH-1:4]};

   // Strict '>' while scanning upward keeps the lowest ID on equal priorities.
   always_comb begin
      best_id   = 2'd0;
      best_prio = '0;
      for (int i = 1; i <= 3; i++) begin
         candidates[i] = pending[i] & enable[i] & (prio[i] != '0);
         if (candidates[i] && (prio[i] > best_prio)) begin
            best_id   = 2'(i);
            best_prio = prio[i];
         end
      end
   end

   assign claim = do_read && (reg_addr == 12'h108) && (best_id != 2'd0);

   // A claim clears pending and also blocks the gateway set in the same cycle.
   always_comb begin
      for (int i = 1; i <= 3; i++) begin
         claim_mask[i]    = claim && (best_id == 2'(i));
         complete_mask[i] = do_write && (reg_addr == 12'h108) && (wr_data[1:0] == 2'(i));
      end
      pending_next   = (pending | (src & ~in_flight)) & ~claim_mask;
      in_flight_next = (in_flight & ~complete_mask) | claim_mask;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_addr)
         12'h004: rd_mux = DATA_WIDTH'(prio[1]);
         12'h008: rd_mux = DATA_WIDTH'(prio[2]);
         12'h00C: rd_mux = DATA_WIDTH'(prio[3]);
         12'h080: rd_mux = DATA_WIDTH'({pending, 1'b0});
         12'h100: rd_mux = DATA_WIDTH'({enable, 1'b0});
         12'h104: rd_mux = DATA_WIDTH'(threshold);
         12'h108: rd_mux = DATA_WIDTH'(best_id);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio      <= '0;
         enable    <= '0;
         threshold <= '0;
         pending   <= '0;
         in_flight <= '0;
         rd_data   <= '0;
         irq_out   <= 1'b0;
      end else begin
         pending   <= pending_next;
         in_flight <= in_flight_next;
         irq_out   <= (best_id != 2'd0) && (best_prio > threshold);
         if (do_read) begin
            rd_data <= rd_mux;
         end
         if (do_write) begin
            case (reg_addr)
               12'h004: prio[1]   <= wr_data[PRIO_BITS-1:0];
               12'h008: prio[2]   <= wr_data[PRIO_BITS-1:0];
               12'h00C: prio[3]   <= wr_data[PRIO_BITS-1:0];
               12'h100: enable    <= wr_data[3:1];
               12'h104: threshold <= wr_data[PRIO_BITS-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_plic_core.sv
// Directed testbench for plic_core: register access, gateway, arbitration,
// threshold, claim/complete and asynchronous reset behaviour.
module tb_plic_core;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        aes_interrupt = 1'b0;
   logic        dma_interrupt = 1'b0;
   logic        sd_host_interrupt = 1'b0;
   logic [31:0] addr = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        irq_out;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] rv;

   plic_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_BITS(3)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .aes_interrupt     (aes_interrupt),
      .dma_interrupt     (dma_interrupt),
      .sd_host_interrupt (sd_host_interrupt),
      .addr              (addr),
      .wr_en             (wr_en),
      .rd_en             (rd_en),
      .wr_data           (wr_data),
      .rd_data           (rd_data),
      .irq_out           (irq_out)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change on the falling edge so the DUT sees them stable at the rising edge.
   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) @(negedge clk_i);
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk_i);
      addr = 32'(a); wr_data = d; wr_en = 1'b1;
      @(negedge clk_i);
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
      @(negedge clk_i);
      addr = 32'(a); rd_en = 1'b1;
      @(negedge clk_i);
      rd_en = 1'b0;
      d = rd_data;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      aes_interrupt = 1'b0; dma_interrupt = 1'b0; sd_host_interrupt = 1'b0;
      cyc(2);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_irq: got %0h expected 0", irq_out); end
      n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rd_data: got %0h expected 0", rd_data); end
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL reset_pending: got %0h expected 0", rv); end
      bus_read(12'h100, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL reset_enable: got %0h expected 0", rv); end
      // Write-then-read of PRIO and an unmapped write/read
      bus_write(12'h00C, 32'hFFFF_FFFE);
      bus_read(12'h00C, rv);
      n_cmp++; if (rv !== 32'h6) begin n_err++; $display("[TB] FAIL prio3_rw: got %0h expected 6", rv); end
      bus_write(12'h100, 32'hF);
      bus_read(12'h100, rv);
      n_cmp++; if (rv !== 32'hE) begin n_err++; $display("[TB] FAIL enable_bit0: got %0h expected e", rv); end
      bus_write(12'h000, 32'h7);
      bus_read(12'h000, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL prio0_ro: got %0h expected 0", rv); end
   endtask

   task automatic test_basic();
      do_reset();
      bus_write(12'h004, 32'd3);
      bus_write(12'h100, 32'h2);
      bus_write(12'h104, 32'd0);
      aes_interrupt = 1'b1;
      cyc(1);
      aes_interrupt = 1'b0;
      addr = 32'h080; rd_en = 1'b1;
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL basic_irq_plus1: got %0h expected 0", irq_out); end
      cyc(1);
      n_cmp++; if (rd_data !== 32'h2) begin n_err++; $display("[TB] FAIL basic_pending: got %0h expected 2", rd_data); end
      n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("[TB] FAIL basic_irq_plus2: got %0h expected 1", irq_out); end
      addr = 32'h108;
      cyc(1);
      rd_en = 1'b0;
      n_cmp++; if (rd_data !== 32'h1) begin n_err++; $display("[TB] FAIL basic_claim: got %0h expected 1", rd_data); end
      cyc(1);
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL basic_irq_after_claim: got %0h expected 0", irq_out); end
   endtask

   task automatic test_priority();
      do_reset();
      bus_write(12'h004, 32'd2);
      bus_write(12'h008, 32'd5);
      bus_write(12'h00C, 32'd5);
      bus_write(12'h100, 32'hE);
      aes_interrupt = 1'b1; dma_interrupt = 1'b1; sd_host_interrupt = 1'b1;
      cyc(2);
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd2) begin n_err++; $display("[TB] FAIL prio_claim1: got %0h expected 2", rv); end
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd3) begin n_err++; $display("[TB] FAIL prio_claim2: got %0h expected 3", rv); end
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd1) begin n_err++; $display("[TB] FAIL prio_claim3: got %0h expected 1", rv); end
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd0) begin n_err++; $display("[TB] FAIL prio_claim4: got %0h expected 0", rv); end
      cyc(1);
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL prio_irq_all_inflight: got %0h expected 0", irq_out); end
      aes_interrupt = 1'b0; dma_interrupt = 1'b0; sd_host_interrupt = 1'b0;
   endtask

   task automatic test_threshold();
      do_reset();
      bus_write(12'h00C, 32'd2);
      bus_write(12'h104, 32'd2);
      bus_write(12'h100, 32'h8);
      sd_host_interrupt = 1'b1;
      cyc(3);
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL thr_equal_blocks: got %0h expected 0", irq_out); end
      bus_write(12'h104, 32'd1);
      cyc(1);
      n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("[TB] FAIL thr_lower_fires: got %0h expected 1", irq_out); end
      bus_write(12'h104, 32'd2);
      cyc(1);
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL thr_raise_blocks: got %0h expected 0", irq_out); end
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd3) begin n_err++; $display("[TB] FAIL thr_claim_anyway: got %0h expected 3", rv); end
      sd_host_interrupt = 1'b0;
   endtask

   task automatic test_complete();
      do_reset();
      bus_write(12'h008, 32'd1);
      bus_write(12'h100, 32'h4);
      dma_interrupt = 1'b1;
      cyc(2);
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd2) begin n_err++; $display("[TB] FAIL cpl_claim: got %0h expected 2", rv); end
      cyc(2);
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL cpl_masked: got %0h expected 0", rv); end
      bus_write(12'h108, 32'd2);
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h4) begin n_err++; $display("[TB] FAIL cpl_repend: got %0h expected 4", rv); end
      bus_write(12'h108, 32'd1);
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h4) begin n_err++; $display("[TB] FAIL cpl_not_inflight: got %0h expected 4", rv); end
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd2) begin n_err++; $display("[TB] FAIL cpl_reclaim: got %0h expected 2", rv); end
      dma_interrupt = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus_write(12'h004, 32'd1);
      bus_write(12'h100, 32'h2);
      aes_interrupt = 1'b1;
      cyc(2);
      bus_read(12'h108, rv);
      n_cmp++; if (rv !== 32'd1) begin n_err++; $display("[TB] FAIL race_claim: got %0h expected 1", rv); end
      cyc(2);
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL race_no_repend: got %0h expected 0", rv); end
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL race_irq: got %0h expected 0", irq_out); end
      bus_read(12'h004, rv);
      @(negedge clk_i);
      addr = 32'h100; wr_data = 32'hE; wr_en = 1'b1; rd_en = 1'b1;
      @(negedge clk_i);
      wr_en = 1'b0; rd_en = 1'b0;
      n_cmp++; if (rd_data !== 32'h1) begin n_err++; $display("[TB] FAIL wr_rd_collision_rd: got %0h expected 1", rd_data); end
      bus_read(12'h100, rv);
      n_cmp++; if (rv !== 32'hE) begin n_err++; $display("[TB] FAIL wr_rd_collision_wr: got %0h expected e", rv); end
      aes_interrupt = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus_write(12'h008, 32'd4);
      bus_write(12'h100, 32'h4);
      dma_interrupt = 1'b1;
      cyc(3);
      n_cmp++; if (irq_out !== 1'b1) begin n_err++; $display("[TB] FAIL rst_pre_irq: got %0h expected 1", irq_out); end
      addr = 32'h108; rd_en = 1'b1;
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      n_cmp++; if (irq_out !== 1'b0) begin n_err++; $display("[TB] FAIL rst_irq: got %0h expected 0", irq_out); end
      n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("[TB] FAIL rst_rd_data: got %0h expected 0", rd_data); end
      rd_en = 1'b0;
      cyc(2);
      rst_i = 1'b0;
      addr = 32'h080; rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("[TB] FAIL rst_pending_clear: got %0h expected 0", rd_data); end
      bus_read(12'h080, rv);
      n_cmp++; if (rv !== 32'h4) begin n_err++; $display("[TB] FAIL rst_repend: got %0h expected 4", rv); end
      bus_read(12'h100, rv);
      n_cmp++; if (rv !== 32'h0) begin n_err++; $display("[TB] FAIL rst_enable: got %0h expected 0", rv); end
      dma_interrupt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_threshold();
      test_complete();
      test_back_to_back();
      test_reset_mid();
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
